// File: rtl/lzs_pkg.sv
// Shared types and constants for the LZS token parser.
// Field widths follow the LZS bit-stream layout (13-bit look-ahead window).
package lzs_pkg;

    typedef enum logic [1:0] {
        ST_HALT,
        ST_TOKEN,
        ST_LEN,
        ST_EXT
    } state_t;

    localparam logic [1:0] KIND_LIT  = 2'b00;
    localparam logic [1:0] KIND_COPY = 2'b01;
    localparam logic [1:0] KIND_END  = 2'b10;

    localparam int WIN_W  = 13;
    localparam int OFF_W  = 11;
    localparam int BYTE_W = 8;

    localparam logic [3:0] LEN_BASE_EXT = 4'd8;
    localparam logic [3:0] EXT_NIBBLE   = 4'hF;

endpackage

// File: rtl/lzs_len_decode.sv
// Decodes the leading length code of an LZS copy: field width, base length, extension flag.
// Purely combinational; no backpressure.
module lzs_len_decode
    import lzs_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] width,
    output logic [3:0] base_len,
    output logic       extend
);

    always_comb begin
        width    = 4'd2;
        base_len = 4'd2;
        extend   = 1'b0;
        if (!code[3]) begin
            base_len = code[2] ? 4'd3 : 4'd2;
        end else if (!code[2]) begin
            base_len = 4'd4;
        end else begin
            // 11xx: 1100..1110 give 5..7, 1111 gives 8 and opens the nibble chain
            width    = 4'd4;
            base_len = 4'd5 + {2'b00, code[1:0]};
            extend   = (code == EXT_NIBBLE);
        end
    end

endmodule

// File: rtl/lzs_token_parser.sv
// LZS token parser: sequences the bit unpacker and emits literal/copy/end tokens.
// Latency: literal 1 cycle after its ack; copy after its last length field ack.
// Backpressure: no ack while the token slot is occupied and the field would emit.
module lzs_token_parser
    import lzs_pkg::*;
#(
    parameter int LEN_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIN_W-1:0]   stream_data,
    input  logic               stream_valid,
    output logic [3:0]         stream_width,
    output logic               stream_ack,
    output logic               tok_valid,
    input  logic               tok_ready,
    output logic [1:0]         tok_kind,
    output logic [BYTE_W-1:0]  tok_byte,
    output logic [OFF_W-1:0]   tok_offset,
    output logic [LEN_W-1:0]   tok_length,
    output logic               len_sat
);

    localparam logic [LEN_W:0] LEN_MAX_X = {1'b0, {LEN_W{1'b1}}};

    state_t             state;
    logic [OFF_W-1:0]   offset_q;
    logic [LEN_W-1:0]   acc_q;

    logic               slot_free;
    logic [3:0]         dec_width;
    logic [3:0]         dec_base;
    logic               dec_extend;
    logic [LEN_W:0]     ext_sum;
    logic               ext_sat;
    logic [LEN_W-1:0]   ext_len;
    logic               ext_more;

    assign slot_free = !tok_valid || tok_ready;

    lzs_len_decode u_len_decode (
        .code     (stream_data[12:9]),
        .width    (dec_width),
        .base_len (dec_base),
        .extend   (dec_extend)
    );

    assign ext_sum  = {1'b0, acc_q} + {{(LEN_W-3){1'b0}}, stream_data[12:9]};
    assign ext_sat  = (ext_sum > LEN_MAX_X);
    assign ext_len  = ext_sat ? LEN_MAX_X[LEN_W-1:0] : ext_sum[LEN_W-1:0];
    assign ext_more = (stream_data[12:9] == EXT_NIBBLE);

    // Fields that keep the parser mid-copy need no slot; fields that emit do.
    always_comb begin
        stream_width = 4'd0;
        stream_ack   = 1'b0;
        case (state)
            ST_TOKEN: begin
                if (stream_valid && slot_free) begin
                    stream_ack   = 1'b1;
                    stream_width = (stream_data[12:11] == 2'b10) ? 4'd13 : 4'd9;
                end
            end
            ST_LEN: begin
                if (stream_valid && (dec_extend || slot_free)) begin
                    stream_ack   = 1'b1;
                    stream_width = dec_width;
                end
            end
            ST_EXT: begin
                if (stream_valid && (ext_more || slot_free)) begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HALT;
            offset_q   <= '0;
            acc_q      <= '0;
            tok_valid  <= 1'b0;
            tok_kind   <= KIND_LIT;
            tok_byte   <= '0;
            tok_offset <= '0;
            tok_length <= '0;
            len_sat    <= 1'b0;
        end else begin
            if (tok_valid && tok_ready) begin
                tok_valid <= 1'b0;
            end
            if (start) begin
                len_sat <= 1'b0;
            end
            case (state)
                ST_HALT: begin
                    if (start) begin
                        state <= ST_TOKEN;
                    end
                end
                ST_TOKEN: begin
                    if (stream_ack) begin
                        if (!stream_data[12]) begin
                            tok_valid <= 1'b1;
                            tok_kind  <= KIND_LIT;
                            tok_byte  <= stream_data[11:4];
                        end else if (stream_data[11]) begin
                            if (stream_data[10:4] != 7'd0) begin
                                offset_q <= {4'd0, stream_data[10:4]};
                                state    <= ST_LEN;
                            end else begin
                                tok_valid <= 1'b1;
                                tok_kind  <= KIND_END;
                                state     <= ST_HALT;
                            end
                        end else begin
                            offset_q <= stream_data[10:0];
                            state    <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    if (stream_ack) begin
                        if (dec_extend) begin
                            acc_q <= LEN_W'(LEN_BASE_EXT);
                            state <= ST_EXT;
                        end else begin
                            tok_valid  <= 1'b1;
                            tok_kind   <= KIND_COPY;
                            tok_offset <= offset_q;
                            tok_length <= LEN_W'(dec_base);
                            state      <= ST_TOKEN;
                        end
                    end
                end
                ST_EXT: begin
                    if (stream_ack) begin
                        acc_q <= ext_len;
                        if (ext_sat) begin
                            len_sat <= 1'b1;
                        end
                        if (!ext_more) begin
                            tok_valid  <= 1'b1;
                            tok_kind   <= KIND_COPY;
                            tok_offset <= offset_q;
                            tok_length <= ext_len;
                            state      <= ST_TOKEN;
                        end
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_lzs_token_parser.sv
// Bench for lzs_token_parser: bit-queue unpacker model plus token and ack-width scoreboards.
module tb_lzs_token_parser;
    import lzs_pkg::*;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  byt;
        logic [10:0] off;
        logic [11:0] len;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // instance A: default length width
    logic        start_a, stream_valid_a, stream_ack_a, tok_valid_a, tok_ready_a, len_sat_a;
    logic [12:0] stream_data_a;
    logic [3:0]  stream_width_a;
    logic [1:0]  tok_kind_a;
    logic [7:0]  tok_byte_a;
    logic [10:0] tok_offset_a;
    logic [11:0] tok_length_a;

    // instance B: narrow length to reach saturation
    logic        start_b, stream_valid_b, stream_ack_b, tok_valid_b, tok_ready_b, len_sat_b;
    logic [12:0] stream_data_b;
    logic [3:0]  stream_width_b;
    logic [1:0]  tok_kind_b;
    logic [7:0]  tok_byte_b;
    logic [10:0] tok_offset_b;
    logic [4:0]  tok_length_b;

    lzs_token_parser dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .stream_data(stream_data_a), .stream_valid(stream_valid_a),
        .stream_width(stream_width_a), .stream_ack(stream_ack_a),
        .tok_valid(tok_valid_a), .tok_ready(tok_ready_a), .tok_kind(tok_kind_a),
        .tok_byte(tok_byte_a), .tok_offset(tok_offset_a), .tok_length(tok_length_a),
        .len_sat(len_sat_a)
    );

    lzs_token_parser #(.LEN_W(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .stream_data(stream_data_b), .stream_valid(stream_valid_b),
        .stream_width(stream_width_b), .stream_ack(stream_ack_b),
        .tok_valid(tok_valid_b), .tok_ready(tok_ready_b), .tok_kind(tok_kind_b),
        .tok_byte(tok_byte_b), .tok_offset(tok_offset_b), .tok_length(tok_length_b),
        .len_sat(len_sat_b)
    );

    int   total = 0;
    int   bad   = 0;
    bit   bits_a[$];
    bit   bits_b[$];
    int   exp_ack_a[$];
    int   exp_ack_b[$];
    exp_t exp_tok_a[$];
    exp_t exp_tok_b[$];

    task automatic push_a(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits_a.push_back(v[i]);
    endtask

    task automatic push_b(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits_b.push_back(v[i]);
    endtask

    function automatic exp_t mk(input logic [1:0] k, input logic [7:0] b,
                                input logic [10:0] o, input logic [11:0] l);
        exp_t e;
        e.kind = k; e.byt = b; e.off = o; e.len = l;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Unpacker model A: consume the acked width, then present the next window.
    initial begin
        logic        a;
        logic [3:0]  w;
        logic [12:0] win;
        stream_data_a  = '0;
        stream_valid_a = 1'b0;
        forever begin
            @(negedge clk);
            a = stream_ack_a;
            w = stream_width_a;
            @(posedge clk);
            #1;
            if (a && !rst) begin
                total++;
                if (exp_ack_a.size() == 0) begin
                    bad++;
                    $display("FAIL ack_a unexpected: width=%0d, none expected", w);
                end else begin
                    int e;
                    e = exp_ack_a.pop_front();
                    if (int'(w) !== e) begin
                        bad++;
                        $display("FAIL ack_a width: got %0d want %0d", w, e);
                    end
                end
                for (int i = 0; i < int'(w); i++)
                    if (bits_a.size() > 0) void'(bits_a.pop_front());
            end
            win = '0;
            for (int i = 0; i < 13; i++) win[12-i] = (i < bits_a.size()) ? bits_a[i] : 1'b0;
            stream_data_a  = win;
            stream_valid_a = (bits_a.size() > 0);
        end
    end

    initial begin
        logic        a;
        logic [3:0]  w;
        logic [12:0] win;
        stream_data_b  = '0;
        stream_valid_b = 1'b0;
        forever begin
            @(negedge clk);
            a = stream_ack_b;
            w = stream_width_b;
            @(posedge clk);
            #1;
            if (a && !rst) begin
                total++;
                if (exp_ack_b.size() == 0) begin
                    bad++;
                    $display("FAIL ack_b unexpected: width=%0d, none expected", w);
                end else begin
                    int e;
                    e = exp_ack_b.pop_front();
                    if (int'(w) !== e) begin
                        bad++;
                        $display("FAIL ack_b width: got %0d want %0d", w, e);
                    end
                end
                for (int i = 0; i < int'(w); i++)
                    if (bits_b.size() > 0) void'(bits_b.pop_front());
            end
            win = '0;
            for (int i = 0; i < 13; i++) win[12-i] = (i < bits_b.size()) ? bits_b[i] : 1'b0;
            stream_data_b  = win;
            stream_valid_b = (bits_b.size() > 0);
        end
    end

    // Token monitors: a token is taken when valid and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (!rst && tok_valid_a && tok_ready_a) begin
            total++;
            if (exp_tok_a.size() == 0) begin
                bad++;
                $display("FAIL tok_a unexpected: kind=%0d byte=%h", tok_kind_a, tok_byte_a);
            end else begin
                exp_t e;
                bit   ok;
                e  = exp_tok_a.pop_front();
                ok = (tok_kind_a === e.kind);
                if (e.kind == KIND_LIT)  ok = ok && (tok_byte_a === e.byt);
                if (e.kind == KIND_COPY) ok = ok && (tok_offset_a === e.off) && (tok_length_a === e.len);
                if (!ok) begin
                    bad++;
                    $display("FAIL tok_a: got kind=%0d byte=%h off=%0d len=%0d want kind=%0d byte=%h off=%0d len=%0d",
                             tok_kind_a, tok_byte_a, tok_offset_a, tok_length_a, e.kind, e.byt, e.off, e.len);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && tok_valid_b && tok_ready_b) begin
            total++;
            if (exp_tok_b.size() == 0) begin
                bad++;
                $display("FAIL tok_b unexpected: kind=%0d len=%0d", tok_kind_b, tok_length_b);
            end else begin
                exp_t e;
                e = exp_tok_b.pop_front();
                if (tok_kind_b !== e.kind || tok_offset_b !== e.off || {7'd0, tok_length_b} !== e.len) begin
                    bad++;
                    $display("FAIL tok_b: got kind=%0d off=%0d len=%0d want kind=%0d off=%0d len=%0d",
                             tok_kind_b, tok_offset_b, tok_length_b, e.kind, e.off, e.len);
                end
            end
        end
    end

    task automatic wait_idle_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bits_a.size() == 0 && exp_ack_a.size() == 0 && exp_tok_a.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic wait_idle_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bits_b.size() == 0 && exp_ack_b.size() == 0 && exp_tok_b.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        tok_ready_a = 1'b0; tok_ready_b = 1'b0;
        step(); step();
        @(negedge clk);
        total++; if (tok_valid_a !== 1'b0)   begin bad++; $display("FAIL reset tok_valid: got %b want 0", tok_valid_a); end
        total++; if (tok_kind_a !== 2'd0)    begin bad++; $display("FAIL reset tok_kind: got %0d want 0", tok_kind_a); end
        total++; if (tok_byte_a !== 8'd0)    begin bad++; $display("FAIL reset tok_byte: got %h want 0", tok_byte_a); end
        total++; if (tok_offset_a !== 11'd0) begin bad++; $display("FAIL reset tok_offset: got %0d want 0", tok_offset_a); end
        total++; if (tok_length_a !== 12'd0) begin bad++; $display("FAIL reset tok_length: got %0d want 0", tok_length_a); end
        total++; if (len_sat_a !== 1'b0)     begin bad++; $display("FAIL reset len_sat: got %b want 0", len_sat_a); end
        total++; if (stream_ack_a !== 1'b0)  begin bad++; $display("FAIL reset stream_ack: got %b want 0", stream_ack_a); end
        total++; if (stream_width_a !== 4'd0) begin bad++; $display("FAIL reset stream_width: got %0d want 0", stream_width_a); end
        step();
        rst = 1'b0;
        step();
        start_a = 1'b1; start_b = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic test_literal();
        bit ok;
        bit seen;
        tok_ready_a = 1'b1;
        push_a({23'd0, 1'b0, 8'h41}, 9);
        exp_ack_a.push_back(9);
        exp_tok_a.push_back(mk(KIND_LIT, 8'h41, 11'd0, 12'd0));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stream_ack_a) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        total++;
        if (!seen || tok_valid_a !== 1'b1 || tok_byte_a !== 8'h41) begin
            bad++;
            $display("FAIL literal latency: ack_seen=%b valid=%b byte=%h want 1 1 41", seen, tok_valid_a, tok_byte_a);
        end
        wait_idle_a(ok);
        total++; if (!ok) begin bad++; $display("FAIL literal drain: timed out, want idle"); end
    endtask

    task automatic test_short_copy();
        bit ok;
        push_a({23'd0, 9'b1_1_0000101}, 9);
        push_a({30'd0, 2'b01}, 2);
        exp_ack_a.push_back(9);
        exp_ack_a.push_back(2);
        exp_tok_a.push_back(mk(KIND_COPY, 8'd0, 11'd5, 12'd3));
        wait_idle_a(ok);
        total++; if (!ok) begin bad++; $display("FAIL short_copy drain: timed out, want idle"); end
    endtask

    task automatic test_long_copy();
        bit ok;
        push_a({19'd0, 13'b1_0_00000000011}, 13);
        push_a(32'hF, 4); push_a(32'hF, 4); push_a(32'h2, 4);
        exp_ack_a.push_back(13);
        for (int i = 0; i < 3; i++) exp_ack_a.push_back(4);
        exp_tok_a.push_back(mk(KIND_COPY, 8'd0, 11'd3, 12'd25));
        wait_idle_a(ok);
        total++; if (!ok) begin bad++; $display("FAIL long_copy drain: timed out, want idle"); end
        total++; if (len_sat_a !== 1'b0) begin bad++; $display("FAIL long_copy len_sat: got %b want 0", len_sat_a); end
    endtask

    task automatic test_end_and_restart();
        bit ok;
        push_a({23'd0, 9'b1_1_0000000}, 9);
        exp_ack_a.push_back(9);
        exp_tok_a.push_back(mk(KIND_END, 8'd0, 11'd0, 12'd0));
        wait_idle_a(ok);
        total++; if (!ok) begin bad++; $display("FAIL end drain: timed out, want idle"); end
        push_a({23'd0, 1'b0, 8'h5A}, 9);
        for (int i = 0; i < 8; i++) step();
        total++; if (bits_a.size() !== 9) begin bad++; $display("FAIL halt hold: %0d bits left, want 9", bits_a.size()); end
        exp_ack_a.push_back(9);
        exp_tok_a.push_back(mk(KIND_LIT, 8'h5A, 11'd0, 12'd0));
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_idle_a(ok);
        total++; if (!ok) begin bad++; $display("FAIL restart drain: timed out, want idle"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit gap;
        bit seen;
        tok_ready_a = 1'b0;
        push_a({23'd0, 1'b0, 8'h11}, 9);
        push_a({23'd0, 1'b0, 8'h22}, 9);
        exp_ack_a.push_back(9); exp_ack_a.push_back(9);
        exp_tok_a.push_back(mk(KIND_LIT, 8'h11, 11'd0, 12'd0));
        exp_tok_a.push_back(mk(KIND_LIT, 8'h22, 11'd0, 12'd0));
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        total++;
        if (tok_valid_a !== 1'b1 || tok_byte_a !== 8'h11 || stream_ack_a !== 1'b0 || bits_a.size() !== 9) begin
            bad++;
            $display("FAIL stall: valid=%b byte=%h ack=%b bits=%0d want 1 11 0 9",
                     tok_valid_a, tok_byte_a, stream_ack_a, bits_a.size());
        end
        step();
        tok_ready_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (tok_valid_a !== 1'b1 || tok_byte_a !== 8'h22) begin
            bad++;
            $display("FAIL no_bubble: valid=%b byte=%h want 1 22", tok_valid_a, tok_byte_a);
        end
        wait_idle_a(ok);
        total++; if (!ok) begin bad++; $display("FAIL back_to_back drain: timed out, want idle"); end
        // streaming literals: one ack every cycle
        for (int i = 0; i < 4; i++) begin
            push_a({23'd0, 1'b0, 8'(8'hA0 + i)}, 9);
            exp_ack_a.push_back(9);
            exp_tok_a.push_back(mk(KIND_LIT, 8'(8'hA0 + i), 11'd0, 12'd0));
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stream_ack_a) begin seen = 1'b1; break; end
        end
        gap = !seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!stream_ack_a) gap = 1'b1;
        end
        total++; if (gap) begin bad++; $display("FAIL throughput: ack gap seen=%b, want 4 consecutive acks", seen); end
        wait_idle_a(ok);
        total++; if (!ok) begin bad++; $display("FAIL throughput drain: timed out, want idle"); end
    endtask

    task automatic test_saturation();
        bit        ok;
        int        acc;
        int        nib [3] = '{15, 15, 0};
        tok_ready_b = 1'b1;
        push_b({23'd0, 9'b1_1_0000001}, 9);
        push_b(32'hF, 4);
        exp_ack_b.push_back(9);
        exp_ack_b.push_back(4);
        acc = 8;
        for (int i = 0; i < 3; i++) begin
            push_b(32'(nib[i]), 4);
            exp_ack_b.push_back(4);
            acc = (acc + nib[i] > 31) ? 31 : acc + nib[i];
        end
        exp_tok_b.push_back(mk(KIND_COPY, 8'd0, 11'd1, 12'(acc)));
        wait_idle_b(ok);
        total++; if (!ok) begin bad++; $display("FAIL sat drain: timed out, want idle"); end
        @(negedge clk);
        total++; if (len_sat_b !== 1'b1) begin bad++; $display("FAIL sat len_sat set: got %b want 1", len_sat_b); end
        step();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        @(negedge clk);
        total++; if (len_sat_b !== 1'b0) begin bad++; $display("FAIL sat len_sat clear: got %b want 0", len_sat_b); end
        total++; if (len_sat_a !== 1'b0) begin bad++; $display("FAIL sat isolation: len_sat_a=%b want 0", len_sat_a); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_literal();
        test_short_copy();
        test_long_copy();
        test_end_and_restart();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
